// File: rtl/axi_lite_xbar_pkg.sv
// Shared types and constants for the 1-master / 2-slave AXI-Lite crossbar.
package axi_lite_xbar_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_S0,
      RD_S1,
      RD_ERR,
      WR_S0,
      WR_S1,
      WR_ERR
   } state_t;

   typedef enum logic [1:0] {
      TGT_S0,
      TGT_S1,
      TGT_ERR
   } tgt_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   // Default map: s0 = 128 MiB SRAM, s1 = 4 KiB UART/CLINT window
   localparam logic [31:0] S0_BASE_DEF = 32'h8000_0000;
   localparam logic [31:0] S0_MASK_DEF = 32'hF800_0000;
   localparam logic [31:0] S1_BASE_DEF = 32'hA000_0000;
   localparam logic [31:0] S1_MASK_DEF = 32'hFFFF_F000;

   function automatic logic addr_match(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/axi_lite_xbar_if.sv
// AXI-Lite channel bundle; master drives requests, slave drives responses.
interface axi_lite_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/axi_lite_addr_decode.sv
// Combinational address decoder: maps an address onto s0, s1 or the error target.
module axi_lite_addr_decode
   import axi_lite_xbar_pkg::*;
#(
   parameter logic [31:0] S0_BASE = S0_BASE_DEF,
   parameter logic [31:0] S0_MASK = S0_MASK_DEF,
   parameter logic [31:0] S1_BASE = S1_BASE_DEF,
   parameter logic [31:0] S1_MASK = S1_MASK_DEF
) (
   input  logic [31:0] addr,
   output tgt_t        tgt
);

   // s0 is tested first so it wins when the windows overlap
   always_comb begin
      if (addr_match(addr, S0_BASE, S0_MASK))
         tgt = TGT_S0;
      else if (addr_match(addr, S1_BASE, S1_MASK))
         tgt = TGT_S1;
      else
         tgt = TGT_ERR;
   end

endmodule

// File: rtl/axi_lite_xbar.sv
// 1-master, 2-slave AXI-Lite crossbar, one transaction in flight, DECERR for unmapped.
// Optional per-target completion counters when AXI_LITE_XBAR_PERF_EN is defined.
module axi_lite_xbar
   import axi_lite_xbar_pkg::*;
#(
   parameter logic [31:0] S0_BASE = S0_BASE_DEF,
   parameter logic [31:0] S0_MASK = S0_MASK_DEF,
   parameter logic [31:0] S1_BASE = S1_BASE_DEF,
   parameter logic [31:0] S1_MASK = S1_MASK_DEF
) (
   input  logic        clk,
   input  logic        rst,
   axi_lite_if.slave   m,
   axi_lite_if.master  s0,
   axi_lite_if.master  s1
`ifdef AXI_LITE_XBAR_PERF_EN
   ,
   output logic [31:0] perf_s0_cnt,
   output logic [31:0] perf_s1_cnt,
   output logic [31:0] perf_err_cnt
`endif
);

   state_t state, state_nxt;
   logic   ar_done, ar_done_nxt;
   logic   aw_done, aw_done_nxt;
   logic   w_done, w_done_nxt;
   logic   err_ack, err_ack_nxt;
   tgt_t   rd_tgt, wr_tgt;

   axi_lite_addr_decode #(
      .S0_BASE(S0_BASE), .S0_MASK(S0_MASK), .S1_BASE(S1_BASE), .S1_MASK(S1_MASK)
   ) u_rd_dec (
      .addr(m.araddr),
      .tgt (rd_tgt)
   );

   axi_lite_addr_decode #(
      .S0_BASE(S0_BASE), .S0_MASK(S0_MASK), .S1_BASE(S1_BASE), .S1_MASK(S1_MASK)
   ) u_wr_dec (
      .addr(m.awaddr),
      .tgt (wr_tgt)
   );

   // Response-side inputs of whichever slave the current state routes to
   logic        sel1;
   logic        sl_arready, sl_rvalid, sl_awready, sl_wready, sl_bvalid;
   logic [31:0] sl_rdata;
   logic [1:0]  sl_rresp, sl_bresp;

   assign sel1       = (state == RD_S1) || (state == WR_S1);
   assign sl_arready = sel1 ? s1.arready : s0.arready;
   assign sl_rvalid  = sel1 ? s1.rvalid  : s0.rvalid;
   assign sl_rdata   = sel1 ? s1.rdata   : s0.rdata;
   assign sl_rresp   = sel1 ? s1.rresp   : s0.rresp;
   assign sl_awready = sel1 ? s1.awready : s0.awready;
   assign sl_wready  = sel1 ? s1.wready  : s0.wready;
   assign sl_bvalid  = sel1 ? s1.bvalid  : s0.bvalid;
   assign sl_bresp   = sel1 ? s1.bresp   : s0.bresp;

   logic ar_vld, r_rdy, aw_vld, w_vld, b_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ar_done <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         err_ack <= 1'b0;
      end else begin
         state   <= state_nxt;
         ar_done <= ar_done_nxt;
         aw_done <= aw_done_nxt;
         w_done  <= w_done_nxt;
         err_ack <= err_ack_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      ar_done_nxt = ar_done;
      aw_done_nxt = aw_done;
      w_done_nxt  = w_done;
      err_ack_nxt = err_ack;
      m.arready   = 1'b0;
      m.rdata     = '0;
      m.rresp     = OKAY;
      m.rvalid    = 1'b0;
      m.awready   = 1'b0;
      m.wready    = 1'b0;
      m.bresp     = OKAY;
      m.bvalid    = 1'b0;
      ar_vld      = 1'b0;
      r_rdy       = 1'b0;
      aw_vld      = 1'b0;
      w_vld       = 1'b0;
      b_rdy       = 1'b0;

      case (state)
         IDLE: begin
            ar_done_nxt = 1'b0;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
            err_ack_nxt = 1'b0;
            if (m.arvalid) begin
               case (rd_tgt)
                  TGT_S0:  state_nxt = RD_S0;
                  TGT_S1:  state_nxt = RD_S1;
                  default: state_nxt = RD_ERR;
               endcase
            end else if (m.awvalid && m.wvalid) begin
               case (wr_tgt)
                  TGT_S0:  state_nxt = WR_S0;
                  TGT_S1:  state_nxt = WR_S1;
                  default: state_nxt = WR_ERR;
               endcase
            end
         end

         RD_S0, RD_S1: begin
            ar_vld    = m.arvalid & ~ar_done;
            m.arready = sl_arready & ~ar_done;
            m.rdata   = sl_rdata;
            m.rresp   = sl_rresp;
            m.rvalid  = sl_rvalid;
            r_rdy     = m.rready;
            if (ar_vld && sl_arready)
               ar_done_nxt = 1'b1;
            if (sl_rvalid && m.rready)
               state_nxt = IDLE;
         end

         // AW and W complete independently; a done flag masks the finished channel
         WR_S0, WR_S1: begin
            aw_vld    = m.awvalid & ~aw_done;
            m.awready = sl_awready & ~aw_done;
            w_vld     = m.wvalid & ~w_done;
            m.wready  = sl_wready & ~w_done;
            m.bresp   = sl_bresp;
            m.bvalid  = sl_bvalid;
            b_rdy     = m.bready;
            if (aw_vld && sl_awready)
               aw_done_nxt = 1'b1;
            if (w_vld && sl_wready)
               w_done_nxt = 1'b1;
            if (sl_bvalid && m.bready)
               state_nxt = IDLE;
         end

         RD_ERR: begin
            if (!err_ack) begin
               m.arready   = 1'b1;
               err_ack_nxt = 1'b1;
            end else begin
               m.rvalid = 1'b1;
               m.rresp  = DECERR;
               if (m.rready)
                  state_nxt = IDLE;
            end
         end

         WR_ERR: begin
            if (!err_ack) begin
               m.awready   = 1'b1;
               m.wready    = 1'b1;
               err_ack_nxt = 1'b1;
            end else begin
               m.bvalid = 1'b1;
               m.bresp  = DECERR;
               if (m.bready)
                  state_nxt = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // Slave-side fan-out: everything not routed to a slave is held at zero
   logic rd0, rd1, wr0, wr1;
   assign rd0 = (state == RD_S0);
   assign rd1 = (state == RD_S1);
   assign wr0 = (state == WR_S0);
   assign wr1 = (state == WR_S1);

   assign s0.araddr  = rd0 ? m.araddr : '0;
   assign s0.arvalid = rd0 & ar_vld;
   assign s0.rready  = rd0 & r_rdy;
   assign s0.awaddr  = wr0 ? m.awaddr : '0;
   assign s0.awvalid = wr0 & aw_vld;
   assign s0.wdata   = wr0 ? m.wdata : '0;
   assign s0.wstrb   = wr0 ? m.wstrb : '0;
   assign s0.wvalid  = wr0 & w_vld;
   assign s0.bready  = wr0 & b_rdy;

   assign s1.araddr  = rd1 ? m.araddr : '0;
   assign s1.arvalid = rd1 & ar_vld;
   assign s1.rready  = rd1 & r_rdy;
   assign s1.awaddr  = wr1 ? m.awaddr : '0;
   assign s1.awvalid = wr1 & aw_vld;
   assign s1.wdata   = wr1 ? m.wdata : '0;
   assign s1.wstrb   = wr1 ? m.wstrb : '0;
   assign s1.wvalid  = wr1 & w_vld;
   assign s1.bready  = wr1 & b_rdy;

`ifdef AXI_LITE_XBAR_PERF_EN
   logic rd_cmp, wr_cmp;
   assign rd_cmp = m.rvalid & m.rready;
   assign wr_cmp = m.bvalid & m.bready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_s0_cnt  <= '0;
         perf_s1_cnt  <= '0;
         perf_err_cnt <= '0;
      end else begin
         if ((rd0 && rd_cmp) || (wr0 && wr_cmp))
            perf_s0_cnt <= perf_s0_cnt + 32'd1;
         if ((rd1 && rd_cmp) || (wr1 && wr_cmp))
            perf_s1_cnt <= perf_s1_cnt + 32'd1;
         if ((state == RD_ERR && rd_cmp) || (state == WR_ERR && wr_cmp))
            perf_err_cnt <= perf_err_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axi_lite_xbar.sv
// Directed bench for axi_lite_xbar: vector table plus hand-written reset/perf sequences.
module tb_axi_lite_xbar;
   import axi_lite_xbar_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axi_lite_if m_if ();
   axi_lite_if s0_if ();
   axi_lite_if s1_if ();

`ifdef AXI_LITE_XBAR_PERF_EN
   logic [31:0] perf_s0_cnt, perf_s1_cnt, perf_err_cnt;
`endif

   axi_lite_xbar dut (
      .clk(clk),
      .rst(rst),
      .m  (m_if),
      .s0 (s0_if),
      .s1 (s1_if)
`ifdef AXI_LITE_XBAR_PERF_EN
      ,
      .perf_s0_cnt (perf_s0_cnt),
      .perf_s1_cnt (perf_s1_cnt),
      .perf_err_cnt(perf_err_cnt)
`endif
   );

   logic        o_arvalid[2], o_rready[2], o_awvalid[2], o_wvalid[2], o_bready[2];
   logic [31:0] o_araddr[2], o_awaddr[2], o_wdata[2];
   logic [3:0]  o_wstrb[2];
   assign o_arvalid[0] = s0_if.arvalid;  assign o_arvalid[1] = s1_if.arvalid;
   assign o_rready[0]  = s0_if.rready;   assign o_rready[1]  = s1_if.rready;
   assign o_awvalid[0] = s0_if.awvalid;  assign o_awvalid[1] = s1_if.awvalid;
   assign o_wvalid[0]  = s0_if.wvalid;   assign o_wvalid[1]  = s1_if.wvalid;
   assign o_bready[0]  = s0_if.bready;   assign o_bready[1]  = s1_if.bready;
   assign o_araddr[0]  = s0_if.araddr;   assign o_araddr[1]  = s1_if.araddr;
   assign o_awaddr[0]  = s0_if.awaddr;   assign o_awaddr[1]  = s1_if.awaddr;
   assign o_wdata[0]   = s0_if.wdata;    assign o_wdata[1]   = s1_if.wdata;
   assign o_wstrb[0]   = s0_if.wstrb;    assign o_wstrb[1]   = s1_if.wstrb;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] raddr;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] s_rdata;
      logic [1:0]  s_resp;
      int          a_rdy;
      int          w_rdy;
      int          lat;
      int          rtgt;
      int          wtgt;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_rresp;
      logic [1:0]  exp_bresp;
   } vec_t;

   vec_t vecs[10];

   int n_cmp = 0;
   int n_err = 0;

   int          ar_hs[2], aw_hs[2], w_hs[2], first_touch[2];
   logic [31:0] ar_addr[2], aw_addr[2], w_data[2];
   logic [3:0]  w_strb[2];
   bit          sv_rvalid[2], sv_bvalid[2];
   int          m_arrdy_cyc, m_awrdy_cyc, m_wrdy_cyc;
   logic [31:0] got_rdata;
   logic [1:0]  got_rresp, got_bresp;
   int          r_done_k, b_done_k;
   bit          idle_after;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply_slaves(input vec_t v, input bit a_rdy, input bit w_rdy);
      s0_if.arready = a_rdy;  s1_if.arready = a_rdy;
      s0_if.awready = a_rdy;  s1_if.awready = a_rdy;
      s0_if.wready  = w_rdy;  s1_if.wready  = w_rdy;
      s0_if.rvalid  = sv_rvalid[0];  s1_if.rvalid = sv_rvalid[1];
      s0_if.rdata   = sv_rvalid[0] ? v.s_rdata : 32'h0;
      s1_if.rdata   = sv_rvalid[1] ? v.s_rdata : 32'h0;
      s0_if.rresp   = v.s_resp;  s1_if.rresp = v.s_resp;
      s0_if.bvalid  = sv_bvalid[0];  s1_if.bvalid = sv_bvalid[1];
      s0_if.bresp   = v.s_resp;  s1_if.bresp = v.s_resp;
   endtask

   task automatic run_vec(input vec_t v);
      int k;
      bit r_pend, w_pend, ar_acc, aw_acc, w_acc;
      int cnt[2];
      bit rpend_s[2], b_issued[2];
      for (int s = 0; s < 2; s++) begin
         ar_hs[s] = 0; aw_hs[s] = 0; w_hs[s] = 0; first_touch[s] = -1;
         ar_addr[s] = '0; aw_addr[s] = '0; w_data[s] = '0; w_strb[s] = '0;
         sv_rvalid[s] = 0; sv_bvalid[s] = 0; cnt[s] = 0; rpend_s[s] = 0; b_issued[s] = 0;
      end
      m_arrdy_cyc = 0; m_awrdy_cyc = 0; m_wrdy_cyc = 0;
      got_rdata = 'x; got_rresp = 'x; got_bresp = 'x;
      r_done_k = -1; b_done_k = -1;
      r_pend = v.rd;
      w_pend = v.wr;
      m_if.araddr  = v.raddr;  m_if.arvalid = v.rd;
      m_if.awaddr  = v.waddr;  m_if.awvalid = v.wr;
      m_if.wdata   = v.wdata;  m_if.wstrb   = v.wstrb;  m_if.wvalid = v.wr;
      m_if.rready  = 1'b1;     m_if.bready  = 1'b1;
      k = 0;
      while ((r_pend || w_pend) && k < 80) begin
         apply_slaves(v, k >= v.a_rdy, k >= v.w_rdy);
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            if ((o_arvalid[s] || o_awvalid[s] || o_wvalid[s]) && first_touch[s] < 0)
               first_touch[s] = k;
            if (o_arvalid[s] && k >= v.a_rdy) begin
               ar_hs[s]++; ar_addr[s] = o_araddr[s]; rpend_s[s] = 1; cnt[s] = v.lat;
            end
            if (o_awvalid[s] && k >= v.a_rdy) begin
               aw_hs[s]++; aw_addr[s] = o_awaddr[s];
            end
            if (o_wvalid[s] && k >= v.w_rdy) begin
               w_hs[s]++; w_data[s] = o_wdata[s]; w_strb[s] = o_wstrb[s];
            end
            if (sv_rvalid[s] && o_rready[s]) sv_rvalid[s] = 0;
            if (sv_bvalid[s] && o_bready[s]) sv_bvalid[s] = 0;
         end
         if (m_if.arready) m_arrdy_cyc++;
         if (m_if.awready) m_awrdy_cyc++;
         if (m_if.wready)  m_wrdy_cyc++;
         ar_acc = m_if.arvalid && m_if.arready;
         aw_acc = m_if.awvalid && m_if.awready;
         w_acc  = m_if.wvalid && m_if.wready;
         if (m_if.rvalid && m_if.rready) begin
            got_rdata = m_if.rdata; got_rresp = m_if.rresp; r_pend = 0; r_done_k = k;
         end
         if (m_if.bvalid && m_if.bready) begin
            got_bresp = m_if.bresp; w_pend = 0; b_done_k = k;
         end
         @(posedge clk);
         #1;
         if (ar_acc) m_if.arvalid = 1'b0;
         if (aw_acc) m_if.awvalid = 1'b0;
         if (w_acc)  m_if.wvalid  = 1'b0;
         for (int s = 0; s < 2; s++) begin
            if (rpend_s[s]) begin
               if (cnt[s] == 0) begin sv_rvalid[s] = 1; rpend_s[s] = 0; end
               else cnt[s]--;
            end
            if (aw_hs[s] > 0 && w_hs[s] > 0 && !b_issued[s]) begin
               sv_bvalid[s] = 1; b_issued[s] = 1;
            end
         end
         k++;
      end
      if (r_pend || w_pend) begin
         n_cmp++; n_err++;
         $display("FAIL txn_timeout: got %0d cycles without completion, expected completion", k);
      end
      for (int s = 0; s < 2; s++) begin sv_rvalid[s] = 0; sv_bvalid[s] = 0; end
      apply_slaves(v, 1'b0, 1'b0);
      m_if.arvalid = 1'b0; m_if.awvalid = 1'b0; m_if.wvalid = 1'b0;
      @(negedge clk);
      idle_after = (dut.state == IDLE);
   endtask

   task automatic check_vec(input int i, input vec_t v);
      bit exp_ar, exp_aw;
      for (int s = 0; s < 2; s++) begin
         exp_ar = v.rd && (v.rtgt == s);
         exp_aw = v.wr && (v.wtgt == s);
         chk($sformatf("v%0d_s%0d_ar_count", i, s), ar_hs[s], {31'd0, exp_ar});
         chk($sformatf("v%0d_s%0d_aw_count", i, s), aw_hs[s], {31'd0, exp_aw});
         chk($sformatf("v%0d_s%0d_w_count", i, s), w_hs[s], {31'd0, exp_aw});
         if (exp_ar) chk($sformatf("v%0d_s%0d_araddr", i, s), ar_addr[s], v.raddr);
         if (exp_aw) begin
            chk($sformatf("v%0d_s%0d_awaddr", i, s), aw_addr[s], v.waddr);
            chk($sformatf("v%0d_s%0d_wdata", i, s), w_data[s], v.wdata);
            chk($sformatf("v%0d_s%0d_wstrb", i, s), {28'd0, w_strb[s]}, {28'd0, v.wstrb});
         end
         if (!exp_ar && !exp_aw)
            chk($sformatf("v%0d_s%0d_untouched", i, s), {31'd0, first_touch[s] < 0}, 32'd1);
      end
      if (v.rd) begin
         chk($sformatf("v%0d_rdata", i), got_rdata, v.exp_rdata);
         chk($sformatf("v%0d_rresp", i), {30'd0, got_rresp}, {30'd0, v.exp_rresp});
         if (v.rtgt == 2) chk($sformatf("v%0d_err_arready_cycles", i), m_arrdy_cyc, 32'd1);
      end
      if (v.wr) begin
         chk($sformatf("v%0d_bresp", i), {30'd0, got_bresp}, {30'd0, v.exp_bresp});
         if (v.wtgt == 2) begin
            chk($sformatf("v%0d_err_awready_cycles", i), m_awrdy_cyc, 32'd1);
            chk($sformatf("v%0d_err_wready_cycles", i), m_wrdy_cyc, 32'd1);
         end
      end
      if (v.rd && v.wr) begin
         chk($sformatf("v%0d_write_after_read", i), {31'd0, first_touch[v.wtgt] > r_done_k}, 32'd1);
         chk($sformatf("v%0d_b_after_r", i), {31'd0, b_done_k > r_done_k}, 32'd1);
      end
      chk($sformatf("v%0d_idle_after", i), {31'd0, idle_after}, 32'd1);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_m_ctl"}, {25'd0, m_if.arready, m_if.rvalid, m_if.awready, m_if.wready,
                           m_if.bvalid, m_if.rresp == 2'b00, m_if.bresp == 2'b00}, 32'h3);
      chk({tag, "_m_rdata"}, m_if.rdata, 32'h0);
      chk({tag, "_s_ctl"}, {22'd0, s0_if.arvalid, s0_if.rready, s0_if.awvalid, s0_if.wvalid,
                           s0_if.bready, s1_if.arvalid, s1_if.rready, s1_if.awvalid,
                           s1_if.wvalid, s1_if.bready}, 32'h0);
      chk({tag, "_s_addr"}, s0_if.araddr | s1_if.araddr | s0_if.awaddr | s1_if.awaddr, 32'h0);
   endtask

   initial begin
      vec_t v, vs1;
      bit hs;
      //          rd wr raddr          waddr          wdata          strb     s_rdata        resp  ardy wrdy lat rt wt exp_rdata      rresp  bresp
      vecs[0] = '{1, 0, 32'h8000_0010, 32'h0,         32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00, 1, 1, 3, 0, 0, 32'hDEAD_BEEF, 2'b00, 2'b00};
      vecs[1] = '{0, 1, 32'h0,         32'hA000_03F8, 32'h0000_0041, 4'h1, 32'h0,         2'b00, 1, 3, 0, 0, 1, 32'h0,         2'b00, 2'b00};
      vecs[2] = '{1, 0, 32'h0000_1000, 32'h0,         32'h0,         4'h0, 32'hFFFF_FFFF, 2'b00, 1, 1, 0, 2, 0, 32'h0,         2'b11, 2'b00};
      vecs[3] = '{1, 0, 32'hA000_0FFC, 32'h0,         32'h0,         4'h0, 32'h1234_5678, 2'b10, 0, 0, 1, 1, 0, 32'h1234_5678, 2'b10, 2'b00};
      vecs[4] = '{1, 0, 32'h87FF_FFFC, 32'h0,         32'h0,         4'h0, 32'hCAFE_F00D, 2'b00, 2, 2, 0, 0, 0, 32'hCAFE_F00D, 2'b00, 2'b00};
      vecs[5] = '{1, 0, 32'h8800_0000, 32'h0,         32'h0,         4'h0, 32'h5555_5555, 2'b00, 1, 1, 0, 2, 0, 32'h0,         2'b11, 2'b00};
      vecs[6] = '{1, 0, 32'hA000_1000, 32'h0,         32'h0,         4'h0, 32'h5555_5555, 2'b00, 1, 1, 0, 2, 0, 32'h0,         2'b11, 2'b00};
      vecs[7] = '{0, 1, 32'h0,         32'h8000_0100, 32'h0BAD_C0DE, 4'hF, 32'h0,         2'b10, 2, 1, 0, 0, 0, 32'h0,         2'b00, 2'b10};
      vecs[8] = '{0, 1, 32'h0,         32'hFFFF_FFFC, 32'h7777_7777, 4'h3, 32'h0,         2'b00, 1, 1, 0, 0, 2, 32'h0,         2'b00, 2'b11};
      vecs[9] = '{1, 1, 32'h8000_0000, 32'hA000_0000, 32'h0000_00A5, 4'h1, 32'h1111_2222, 2'b00, 1, 1, 1, 0, 1, 32'h1111_2222, 2'b00, 2'b00};
      vs1     = '{1, 0, 32'hA000_0020, 32'h0,         32'h0,         4'h0, 32'h0BEE_F123, 2'b00, 1, 1, 2, 1, 0, 32'h0BEE_F123, 2'b00, 2'b00};

      rst = 1'b1;
      m_if.araddr = '0; m_if.arvalid = 0; m_if.rready = 0;
      m_if.awaddr = '0; m_if.awvalid = 0; m_if.wdata = '0; m_if.wstrb = '0; m_if.wvalid = 0;
      m_if.bready = 0;
      for (int s = 0; s < 2; s++) begin sv_rvalid[s] = 0; sv_bvalid[s] = 0; end
      apply_slaves(vecs[0], 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk_quiet("reset");
      chk("reset_state", {29'd0, dut.state}, {29'd0, IDLE});
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i]);
         check_vec(i, vecs[i]);
      end

      // Reset while s0 holds rvalid and the master withholds rready
      m_if.araddr = 32'h8000_0040; m_if.arvalid = 1'b1; m_if.rready = 1'b0;
      s0_if.arready = 1'b1;
      hs = 0;
      for (int k = 0; k < 10 && !hs; k++) begin
         @(negedge clk);
         hs = m_if.arvalid && m_if.arready;
      end
      chk("rstmid_ar_handshake", {31'd0, hs}, 32'd1);
      @(posedge clk);
      #1;
      m_if.arvalid = 1'b0;
      s0_if.rvalid = 1'b1; s0_if.rdata = 32'h5A5A_0001; s0_if.rresp = OKAY;
      @(negedge clk);
      chk("rstmid_rvalid_pending", {31'd0, m_if.rvalid}, 32'd1);
      chk("rstmid_rdata_pending", m_if.rdata, 32'h5A5A_0001);
      #1 rst = 1'b1;
      #1;
      chk_quiet("rstmid");
      chk("rstmid_state", {29'd0, dut.state}, {29'd0, IDLE});
      @(negedge clk);
      rst = 1'b0;
      s0_if.rvalid = 1'b0; s0_if.arready = 1'b0; m_if.rready = 1'b1;
      run_vec(vs1);
      check_vec(10, vs1);

`ifdef AXI_LITE_XBAR_PERF_EN
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("perf_clear", perf_s0_cnt | perf_s1_cnt | perf_err_cnt, 32'h0);
      run_vec(vecs[0]);
      run_vec(vecs[4]);
      run_vec(vecs[1]);
      run_vec(vecs[8]);
      chk("perf_s0", perf_s0_cnt, 32'd2);
      chk("perf_s1", perf_s1_cnt, 32'd1);
      chk("perf_err", perf_err_cnt, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
